// File: rtl/bank_pkg.sv
// Shared constants for the bank issue queue and its scheduler.
package bank_pkg;
  localparam int NUM_CH         = 4;
  localparam int CH_W           = 2;
  localparam int CREDIT_MAX_DEF = 4;
  localparam int PTR_W          = 6;

  typedef logic [CH_W-1:0] ch_id_t;
endpackage

// File: rtl/bank_credit_cnt.sv
// Single-channel saturating credit counter; overflow flags a return beyond the maximum.
module bank_credit_cnt #(
  parameter int CW         = 4,
  parameter int CREDIT_MAX = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          rtn_i,
  input  logic          consume_i,
  output logic [CW-1:0] cnt_o,
  output logic          ovf_o
);
  localparam logic [CW-1:0] MAX = CW'(CREDIT_MAX);

  // A return paired with a consume is a net no-op, so it can never overflow.
  assign ovf_o = rtn_i & ~consume_i & (cnt_o == MAX);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      cnt_o <= MAX;
    end else if (rtn_i & ~consume_i & ~ovf_o) begin
      cnt_o <= cnt_o + CW'(1);
    end else if (consume_i & ~rtn_i) begin
      cnt_o <= cnt_o - CW'(1);
    end
  end
endmodule

// File: rtl/bank_isu_sched.sv
// In-order issue scheduler: shadows queue entry state, releases the head once its
// linefill is done and its channel holds a credit.
module bank_isu_sched
  import bank_pkg::*;
#(
  parameter int PTR_WIDH   = PTR_W,
  parameter int CREDIT_MAX = CREDIT_MAX_DEF,
  parameter int CW         = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                enq_valid_i,
  input  logic [PTR_WIDH-1:0] enq_idx_i,
  input  logic                enq_need_linefill_i,
  input  logic [1:0]          enq_ch_id_i,
  input  logic                fill_done_valid_i,
  input  logic [PTR_WIDH-1:0] fill_done_idx_i,
  input  logic [3:0]          credit_rtn_i,
  output logic                issue_valid_o,
  input  logic                issue_ready_i,
  output logic [PTR_WIDH-1:0] issue_idx_o,
  output logic [1:0]          issue_ch_id_o,
  output logic [PTR_WIDH:0]   occupancy_o,
  output logic                err_o
);
  localparam int DEPTH = 1 << PTR_WIDH;
  localparam logic [PTR_WIDH:0] DEPTH_V = (PTR_WIDH+1)'(DEPTH);

  logic [DEPTH-1:0]    valid_q, wait_q;
  ch_id_t              ch_q [DEPTH];
  logic [PTR_WIDH-1:0] head_q, tail_q;
  logic [PTR_WIDH:0]   occ_q;
  logic                err_q;

  logic [CW-1:0]       cr_cnt [NUM_CH];
  logic [NUM_CH-1:0]   cr_ovf, consume;
  ch_id_t              head_ch;
  logic                full, fire, enq_ok, enq_err, fill_hit, fill_err;

  assign head_ch       = ch_q[head_q];
  assign issue_valid_o = valid_q[head_q] & ~wait_q[head_q] & (cr_cnt[head_ch] != '0);
  assign issue_idx_o   = head_q;
  assign issue_ch_id_o = head_ch;
  assign occupancy_o   = occ_q;
  assign err_o         = err_q;

  assign full    = (occ_q == DEPTH_V);
  assign fire    = issue_valid_o & issue_ready_i;
  assign enq_ok  = enq_valid_i & ~full;
  assign enq_err = enq_valid_i & (full | (enq_idx_i != tail_q));
  // A wakeup aimed at the slot being written this cycle sees the old (empty) entry.
  assign fill_hit = fill_done_valid_i & valid_q[fill_done_idx_i] & wait_q[fill_done_idx_i]
                  & ~(enq_ok & (fill_done_idx_i == tail_q));
  assign fill_err = fill_done_valid_i & ~fill_hit;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_credit
    assign consume[c] = fire & (head_ch == CH_W'(c));
    bank_credit_cnt #(.CW(CW), .CREDIT_MAX(CREDIT_MAX)) u_cnt (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .rtn_i     (credit_rtn_i[c]),
      .consume_i (consume[c]),
      .cnt_o     (cr_cnt[c]),
      .ovf_o     (cr_ovf[c])
    );
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      valid_q <= '0;
      wait_q  <= '0;
      for (int i = 0; i < DEPTH; i++) ch_q[i] <= '0;
      head_q  <= '0;
      tail_q  <= '0;
      occ_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      if (fire) begin
        valid_q[head_q] <= 1'b0;
        head_q          <= head_q + PTR_WIDH'(1);
      end
      if (enq_ok) begin
        valid_q[tail_q] <= 1'b1;
        wait_q[tail_q]  <= enq_need_linefill_i;
        ch_q[tail_q]    <= enq_ch_id_i;
        tail_q          <= tail_q + PTR_WIDH'(1);
      end
      if (fill_hit) wait_q[fill_done_idx_i] <= 1'b0;
      case ({enq_ok, fire})
        2'b10:   occ_q <= occ_q + (PTR_WIDH+1)'(1);
        2'b01:   occ_q <= occ_q - (PTR_WIDH+1)'(1);
        default: occ_q <= occ_q;
      endcase
      if (enq_err | fill_err | (|cr_ovf)) err_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_bank_isu_sched.sv
// Bench for bank_isu_sched: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_bank_isu_sched;
  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       enq_valid_i;
  logic [5:0] enq_idx_i;
  logic       enq_need_linefill_i;
  logic [1:0] enq_ch_id_i;
  logic       fill_done_valid_i;
  logic [5:0] fill_done_idx_i;
  logic [3:0] credit_rtn_i;
  logic       issue_valid_o;
  logic       issue_ready_i;
  logic [5:0] issue_idx_o;
  logic [1:0] issue_ch_id_o;
  logic [6:0] occupancy_o;
  logic       err_o;

  always #5 clk_i = ~clk_i;

  bank_isu_sched dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .enq_valid_i(enq_valid_i), .enq_idx_i(enq_idx_i),
    .enq_need_linefill_i(enq_need_linefill_i), .enq_ch_id_i(enq_ch_id_i),
    .fill_done_valid_i(fill_done_valid_i), .fill_done_idx_i(fill_done_idx_i),
    .credit_rtn_i(credit_rtn_i),
    .issue_valid_o(issue_valid_o), .issue_ready_i(issue_ready_i),
    .issue_idx_o(issue_idx_o), .issue_ch_id_o(issue_ch_id_o),
    .occupancy_o(occupancy_o), .err_o(err_o)
  );

  // Reference: the live entries form a FIFO; the front is the head.
  typedef struct { int idx; int ch; bit wt; } ent_t;
  ent_t q[$];
  int   m_head, m_tail;
  int   m_cred [4];
  bit   m_err;
  int   checks = 0, errors = 0;

  function automatic bit m_valid();
    return (q.size() > 0) && !q[0].wt && (m_cred[q[0].ch] > 0);
  endfunction

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk_i) begin
    if (!rst_i) begin
      q.delete();
      m_head = 0;
      m_tail = 0;
      for (int c = 0; c < 4; c++) m_cred[c] = 4;
      m_err = 0;
    end else begin
      bit f, was_full, found;
      int cch;
      f        = m_valid() && issue_ready_i;
      cch      = f ? q[0].ch : -1;
      was_full = (q.size() == 64);
      if (fill_done_valid_i) begin
        found = 0;
        foreach (q[k]) if (q[k].idx == int'(fill_done_idx_i) && q[k].wt) begin
          q[k].wt = 0;
          found = 1;
        end
        if (!found) m_err = 1;
      end
      if (f) begin
        void'(q.pop_front());
        m_head = (m_head + 1) % 64;
      end
      if (enq_valid_i) begin
        if (int'(enq_idx_i) != m_tail || was_full) m_err = 1;
        if (!was_full) begin
          q.push_back('{m_tail, int'(enq_ch_id_i), enq_need_linefill_i});
          m_tail = (m_tail + 1) % 64;
        end
      end
      for (int c = 0; c < 4; c++) begin
        if (credit_rtn_i[c] && c != cch) begin
          if (m_cred[c] == 4) m_err = 1;
          else m_cred[c]++;
        end else if (!credit_rtn_i[c] && c == cch) begin
          m_cred[c]--;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (rst_i) begin
      cmp("issue_valid", issue_valid_o, m_valid());
      cmp("issue_idx", issue_idx_o, m_head);
      if (m_valid()) cmp("issue_ch", issue_ch_id_o, q[0].ch);
      cmp("occupancy", occupancy_o, q.size());
      cmp("err", err_o, m_err);
    end
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    enq_valid_i = 0; enq_idx_i = 0; enq_need_linefill_i = 0; enq_ch_id_i = 0;
    fill_done_valid_i = 0; fill_done_idx_i = 0; credit_rtn_i = 0; issue_ready_i = 0;
  endtask

  task automatic do_reset();
    rst_i = 0;
    idle_inputs();
    cyc(); cyc();
    rst_i = 1;
  endtask

  task automatic enq(input int idx, input int ch, input bit lf);
    enq_valid_i = 1; enq_idx_i = 6'(idx); enq_ch_id_i = 2'(ch); enq_need_linefill_i = lf;
  endtask

  initial begin
    do_reset();
    // Reset then idle
    cyc(); cyc();
    cmp("rst_valid", issue_valid_o, 0);
    cmp("rst_occ", occupancy_o, 0);
    cmp("rst_err", err_o, 0);
    cmp("rst_idx", issue_idx_o, 0);

    // Single no-wait entry on ch 2
    issue_ready_i = 1;
    enq(0, 2, 0);
    cyc();
    enq_valid_i = 0;
    cmp("t2_valid", issue_valid_o, 1);
    cmp("t2_idx", issue_idx_o, 0);
    cmp("t2_ch", issue_ch_id_o, 2);
    cyc();
    cmp("t2_occ", occupancy_o, 0);
    cmp("t2_model_cred2", m_cred[2], 3);

    // In-order block behind a linefill wait
    do_reset();
    issue_ready_i = 1;
    enq(0, 0, 1); cyc();
    enq(1, 3, 0); cyc();
    enq_valid_i = 0;
    cmp("t3_blocked", issue_valid_o, 0);
    cmp("t3_occ", occupancy_o, 2);
    cyc();
    cmp("t3_blocked2", issue_valid_o, 0);
    fill_done_valid_i = 1; fill_done_idx_i = 0;
    cyc();
    fill_done_valid_i = 0;
    cmp("t3_wake_valid", issue_valid_o, 1);
    cmp("t3_wake_idx", issue_idx_o, 0);
    cyc();
    cmp("t3_next_valid", issue_valid_o, 1);
    cmp("t3_next_idx", issue_idx_o, 1);
    cyc();
    cmp("t3_empty", occupancy_o, 0);
    cmp("t3_err", err_o, 0);

    // Credit exhaustion on ch 1
    do_reset();
    for (int i = 0; i < 5; i++) begin enq(i, 1, 0); cyc(); end
    enq_valid_i = 0;
    issue_ready_i = 1;
    repeat (4) cyc();
    cmp("t4_starved", issue_valid_o, 0);
    cmp("t4_occ1", occupancy_o, 1);
    repeat (3) cyc();
    cmp("t4_still_starved", issue_valid_o, 0);
    credit_rtn_i = 4'b0010;
    cyc();
    credit_rtn_i = 0;
    cmp("t4_rtn_valid", issue_valid_o, 1);
    cmp("t4_rtn_idx", issue_idx_o, 4);
    cyc();
    cmp("t4_drained", occupancy_o, 0);
    cmp("t4_model_cred1", m_cred[1], 0);
    credit_rtn_i = 4'b0010; cyc(); credit_rtn_i = 0;
    issue_ready_i = 0;
    enq(5, 1, 0); cyc();
    enq(6, 1, 0); cyc();
    enq_valid_i = 0;
    issue_ready_i = 1; credit_rtn_i = 4'b0010;
    cyc();
    credit_rtn_i = 0;
    cmp("t4_model_cred_flat", m_cred[1], 1);
    cmp("t4_second_valid", issue_valid_o, 1);
    cmp("t4_second_idx", issue_idx_o, 6);
    cyc();
    cmp("t4_final_occ", occupancy_o, 0);
    cmp("t4_err", err_o, 0);

    // Fill, drain, refill across the pointer wrap
    do_reset();
    for (int i = 0; i < 64; i++) begin enq(i, i % 4, 0); cyc(); end
    enq_valid_i = 0;
    cmp("t5_full", occupancy_o, 64);
    cmp("t5_full_err", err_o, 0);
    issue_ready_i = 1;
    for (int i = 0; i < 64; i++) begin credit_rtn_i = 4'(1 << (i % 4)); cyc(); end
    credit_rtn_i = 0; issue_ready_i = 0;
    cmp("t5_empty", occupancy_o, 0);
    cmp("t5_head_wrap", issue_idx_o, 0);
    cmp("t5_empty_err", err_o, 0);
    for (int i = 0; i < 64; i++) begin enq(i, 3 - (i % 4), 0); cyc(); end
    enq_valid_i = 0;
    cmp("t5_refull", occupancy_o, 64);
    cmp("t5_refull_err", err_o, 0);

    // Enqueue while full is dropped and flagged
    enq(0, 1, 0); cyc(); enq_valid_i = 0;
    cmp("e_full_err", err_o, 1);
    cmp("e_full_occ", occupancy_o, 64);
    cyc(); cyc();
    cmp("e_full_sticky", err_o, 1);

    // Reset mid-operation
    do_reset();
    cmp("mid_rst_occ", occupancy_o, 0);
    cmp("mid_rst_err", err_o, 0);
    cmp("mid_rst_valid", issue_valid_o, 0);

    // Return to a channel already at the maximum
    credit_rtn_i = 4'b0001; cyc(); credit_rtn_i = 0;
    cmp("e_ovf_err", err_o, 1);
    cyc();
    cmp("e_ovf_sticky", err_o, 1);

    // Wakeup to an empty slot
    do_reset();
    fill_done_valid_i = 1; fill_done_idx_i = 3; cyc(); fill_done_valid_i = 0;
    cmp("e_fill_err", err_o, 1);

    // Index mismatch still writes the internal tail
    do_reset();
    enq(5, 3, 0); cyc(); enq_valid_i = 0;
    cmp("e_idx_err", err_o, 1);
    cmp("e_idx_valid", issue_valid_o, 1);
    cmp("e_idx_slot", issue_idx_o, 0);
    cmp("e_idx_ch", issue_ch_id_o, 3);

    // Wakeup colliding with the enqueue of the same slot
    do_reset();
    enq(0, 2, 1); fill_done_valid_i = 1; fill_done_idx_i = 0;
    cyc();
    enq_valid_i = 0; fill_done_valid_i = 0;
    cmp("e_coll_err", err_o, 1);
    cmp("e_coll_wait", issue_valid_o, 0);
    cmp("e_coll_occ", occupancy_o, 1);
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
